// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch debouncer signal bundle (raw switches in, debounced level and strobes out)
interface sw_debounce_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] SW_I;
    logic [WIDTH-1:0] SW_O;
    logic [WIDTH-1:0] RISE_O;
    logic [WIDTH-1:0] FALL_O;
    logic             CHG_O;

    // Drives the switches, observes the conditioned outputs.
    modport master (
        output SW_I,
        input  SW_O,
        input  RISE_O,
        input  FALL_O,
        input  CHG_O
    );

    // The debouncer itself.
    modport slave (
        input  SW_I,
        output SW_O,
        output RISE_O,
        output FALL_O,
        output CHG_O
    );
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-bit synchroniser + stability-counter debouncer; SW_DEBOUNCE_TOGGLE_EN turns SW_O into a per-bit toggle
module sw_debounce #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 1000000
) (
    input  logic         CLK,
    input  logic         RST,
    sw_debounce_if.slave bus
);
    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_stable_next;
    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_fall_next;
    logic [CNT_W-1:0] w_cnt_next [WIDTH];

    // Two-flop synchroniser per bit, nothing between the stages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.SW_I;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit filter: count while the synchronised level differs from the
    // accepted one; any agreement restarts the count, so a bounce costs the
    // full window again. Reaching CNT_MAX accepts the level and resets the
    // counter, which therefore can never wrap.
    always_comb begin
        w_stable_next = r_stable;
        w_rise_next   = '0;
        w_fall_next   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_next[i] = r_sync2[i];
                    w_rise_next[i]   = r_sync2[i];
                    w_fall_next[i]   = ~r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Filter state and strobes update together so RISE_O coincides with the
    // first cycle of the new level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_chg    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_next;
            r_rise   <= w_rise_next;
            r_fall   <= w_fall_next;
            r_chg    <= |(w_rise_next | w_fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign bus.RISE_O = r_rise;
    assign bus.FALL_O = r_fall;
    assign bus.CHG_O  = r_chg;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [WIDTH-1:0] r_toggle;

    // Push-on/push-off: each accepted press flips the bit, releases are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_toggle <= '0;
        end else begin
            r_toggle <= r_toggle ^ w_rise_next;
        end
    end

    assign bus.SW_O = r_toggle;
`else
    assign bus.SW_O = r_stable;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed table-driven bench for sw_debounce with DB_CYCLES=4
module tb_sw_debounce;
    logic CLK = 1'b0;
    logic RST;

    sw_debounce_if #(.WIDTH(16)) bus ();

    sw_debounce #(
        .WIDTH     (16),
        .DB_CYCLES (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] sw_i;
        logic [15:0] level;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        chg;
    } vec_t;

    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_tog = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the expected debounced level and strobes.
    task automatic check_full(input string name, input logic [15:0] level,
                              input logic [15:0] rise, input logic [15:0] fall,
                              input logic chg);
        logic [15:0] exp_o;
`ifdef SW_DEBOUNCE_TOGGLE_EN
        m_tog = m_tog ^ rise;
        exp_o = m_tog;
`else
        exp_o = level;
`endif
        chk({name, ".sw_o"}, 32'(bus.SW_O), 32'(exp_o));
        chk({name, ".rise"}, 32'(bus.RISE_O), 32'(rise));
        chk({name, ".fall"}, 32'(bus.FALL_O), 32'(fall));
        chk({name, ".chg"},  32'(bus.CHG_O),  32'(chg));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // A held change: five edges with the old level, the accepting edge, one quiet edge.
    task automatic add_change(input logic [15:0] sw, input logic [15:0] old_l, input logic [15:0] new_l);
        logic [15:0] r;
        logic [15:0] f;
        r = new_l & ~old_l;
        f = old_l & ~new_l;
        for (int i = 0; i < 5; i++) vecs.push_back('{sw, old_l, 16'h0, 16'h0, 1'b0});
        vecs.push_back('{sw, new_l, r, f, |(r | f)});
        vecs.push_back('{sw, new_l, 16'h0, 16'h0, 1'b0});
    endtask

    // Same held-change pattern, applied directly.
    task automatic run_change(input string name, input logic [15:0] sw,
                              input logic [15:0] old_l, input logic [15:0] new_l);
        logic [15:0] r;
        logic [15:0] f;
        r = new_l & ~old_l;
        f = old_l & ~new_l;
        bus.SW_I = sw;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_full({name, ".hold"}, old_l, 16'h0, 16'h0, 1'b0);
        end
        tick();
        check_full({name, ".edge"}, new_l, r, f, |(r | f));
        tick();
        check_full({name, ".after"}, new_l, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] bounce_pat [8];

        // Reset release with all switches high, then a series of level changes.
        add_change(16'hFFFF, 16'h0000, 16'hFFFF);
        add_change(16'h0000, 16'hFFFF, 16'h0000);
        add_change(16'h0008, 16'h0000, 16'h0008);
        add_change(16'h00F0, 16'h0008, 16'h00F0);
        add_change(16'h000F, 16'h00F0, 16'h000F);
        add_change(16'h0000, 16'h000F, 16'h0000);

        RST      = 1'b1;
        bus.SW_I = 16'hFFFF;
        #22;
        check_full("reset", 16'h0, 16'h0, 16'h0, 1'b0);
        chk("reset.sync1", 32'(dut.r_sync1), 32'h0);
        chk("reset.sync2", 32'(dut.r_sync2), 32'h0);

        @(posedge CLK);
        #3;
        RST = 1'b0;

        foreach (vecs[i]) begin
            bus.SW_I = vecs[i].sw_i;
            tick();
            check_full($sformatf("vec%0d", i), vecs[i].level, vecs[i].rise,
                       vecs[i].fall, vecs[i].chg);
        end

        // Bit 0 bounces with 2-cycle pulses, then settles high.
        bounce_pat = '{16'h1, 16'h1, 16'h0, 16'h0, 16'h1, 16'h1, 16'h0, 16'h0};
        for (int i = 0; i < 8; i++) begin
            bus.SW_I = bounce_pat[i];
            tick();
            check_full($sformatf("bounce%0d", i), 16'h0, 16'h0, 16'h0, 1'b0);
        end
        run_change("bounce_settle", 16'h0001, 16'h0000, 16'h0001);

        // Release bit 0, reset asynchronously while its count sits at 2.
        bus.SW_I = 16'h0000;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst.cnt_before", 32'(dut.r_cnt[0]), 32'd2);
        chk("midrst.sw_before", 32'(bus.SW_O[0]), 32'd1);
        #2;
        RST      = 1'b1;
        bus.SW_I = 16'h0001;
        #1;
        chk("midrst.sw_o", 32'(bus.SW_O), 32'h0);
        chk("midrst.cnt", 32'(dut.r_cnt[0]), 32'h0);
        chk("midrst.stable", 32'(dut.r_stable), 32'h0);
        m_tog = '0;
        #1;
        RST = 1'b0;
        run_change("midrst_restart", 16'h0001, 16'h0000, 16'h0001);

`ifdef SW_DEBOUNCE_TOGGLE_EN
        // Two press/release cycles on bit 5; bit 0 is held pressed throughout.
        run_change("tog_press1", 16'h0021, 16'h0001, 16'h0021);
        chk("tog_press1.bit5", 32'(bus.SW_O[5]), 32'd1);
        run_change("tog_rel1", 16'h0001, 16'h0021, 16'h0001);
        chk("tog_rel1.bit5", 32'(bus.SW_O[5]), 32'd1);
        run_change("tog_press2", 16'h0021, 16'h0001, 16'h0021);
        chk("tog_press2.bit5", 32'(bus.SW_O[5]), 32'd0);
        run_change("tog_rel2", 16'h0001, 16'h0021, 16'h0001);
        chk("tog_rel2.bit5", 32'(bus.SW_O[5]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
